// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - IEEE 802.3 Clause 22 MDIO master, read and write frames
module mdio_master #(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        op_write,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        ta_err,
    output logic        mdCLK,
    inout  wire         MDIO
);

    localparam int PERIOD = 2 * CLK_DIV;
    localparam int DW     = $clog2(PERIOD);
    localparam int MAXLEN = (PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16;
    localparam int BCW    = $clog2(MAXLEN);

    typedef enum logic [2:0] {IDLE, PRE, STOP, ADDR, TA, DATA, FIN} state_t;

    state_t          state, state_next;
    logic [DW-1:0]   div_cnt;
    logic [BCW-1:0]  bit_cnt;
    logic [BCW-1:0]  last_bit;
    logic [31:0]     tx_sr;
    logic [15:0]     rx_sr;
    logic            wr_q;
    logic            in_frame;
    logic            bit_end;
    logic            seg_last;
    logic            accept;
    logic            mdio_oe;
    logic            mdio_out;

    assign in_frame = (state == PRE) || (state == STOP) || (state == ADDR) ||
                      (state == TA)  || (state == DATA);
    assign bit_end  = in_frame && (div_cnt == DW'(PERIOD - 1));
    assign seg_last = bit_end && (bit_cnt == last_bit);
    // done is high during the first IDLE cycle; a start there is still ignored
    assign accept   = (state == IDLE) && start && !done;
    assign mdCLK    = in_frame && (div_cnt >= DW'(CLK_DIV));
    assign MDIO     = mdio_oe ? mdio_out : 1'bz;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        last_bit   = '0;
        mdio_oe    = 1'b0;
        mdio_out   = 1'b1;
        case (state)
            IDLE: if (accept) state_next = (PREAMBLE_LEN == 0) ? STOP : PRE;
            PRE: begin
                last_bit = BCW'(PREAMBLE_LEN - 1);
                mdio_oe  = 1'b1;
                if (seg_last) state_next = STOP;
            end
            STOP: begin
                last_bit = BCW'(3);
                mdio_oe  = 1'b1;
                mdio_out = tx_sr[31];
                if (seg_last) state_next = ADDR;
            end
            ADDR: begin
                last_bit = BCW'(9);
                mdio_oe  = 1'b1;
                mdio_out = tx_sr[31];
                if (seg_last) state_next = TA;
            end
            TA: begin
                last_bit = BCW'(1);
                mdio_oe  = wr_q;
                mdio_out = tx_sr[31];
                if (seg_last) state_next = DATA;
            end
            DATA: begin
                last_bit = BCW'(15);
                mdio_oe  = wr_q;
                mdio_out = tx_sr[31];
                if (seg_last) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            wr_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ta_err  <= 1'b0;
            rd_data <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy    <= 1'b1;
                wr_q    <= op_write;
                tx_sr   <= {2'b01, (op_write ? 2'b01 : 2'b10), phy_addr, reg_addr,
                            2'b10, wr_data};
                div_cnt <= '0;
                bit_cnt <= '0;
            end
            if (in_frame) begin
                div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
                if (bit_end) begin
                    bit_cnt <= seg_last ? '0 : bit_cnt + 1'b1;
                    // preamble bits are constant, so the frame register only moves after it
                    if (state != PRE) tx_sr <= {tx_sr[30:0], 1'b0};
                    if (state == TA && bit_cnt == BCW'(1) && !wr_q) ta_err <= MDIO;
                    if (state == DATA) rx_sr <= {rx_sr[14:0], MDIO};
                end
            end
            if (state == FIN) begin
                busy <= 1'b0;
                done <= 1'b1;
                if (!wr_q) rd_data <= rx_sr;
            end
        end
    end

endmodule
